// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module   : iter_alu
// Purpose  : Handshaked multi-cycle integer ALU with iterative shifts and an
//            optional iterative multiplier (enabled by ITER_ALU_MUL_EN).
// Revision : 1.0  initial release
// ============================================================================
module iter_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             Cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] M_ADD  = 4'd0;
    localparam logic [3:0] M_SUB  = 4'd1;
    localparam logic [3:0] M_NOT  = 4'd2;
    localparam logic [3:0] M_AND  = 4'd3;
    localparam logic [3:0] M_OR   = 4'd4;
    localparam logic [3:0] M_XOR  = 4'd5;
    localparam logic [3:0] M_SLT  = 4'd6;
    localparam logic [3:0] M_SLTU = 4'd7;
    localparam logic [3:0] M_EQ   = 4'd8;
    localparam logic [3:0] M_SLL  = 4'd9;
    localparam logic [3:0] M_SRL  = 4'd10;
    localparam logic [3:0] M_SRA  = 4'd11;
`ifdef ITER_ALU_MUL_EN
    localparam logic [3:0] M_MUL  = 4'd12;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [3:0]       r_mode;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ov;
    logic             r_cout;
    logic [SHW-1:0]   r_cnt;
`ifdef ITER_ALU_MUL_EN
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
`endif

    logic [SHW-1:0]   w_shamt;
    logic             w_accept;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_ov;
    logic             w_sub_ov;
    logic             w_is_shift;
    logic             w_mul_start;
    logic             w_long;
    logic [WIDTH-1:0] w_res;
    logic             w_ov;
    logic             w_cout;
    logic [WIDTH-1:0] w_step;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] x,
                                                input logic [3:0]       m);
        case (m)
            M_SLL:   return {x[WIDTH-2:0], 1'b0};
            M_SRL:   return {1'b0, x[WIDTH-1:1]};
            default: return {x[WIDTH-1], x[WIDTH-1:1]};
        endcase
    endfunction

    assign w_shamt  = B[SHW-1:0];
    assign w_accept = (r_state == S_IDLE) & in_valid;

    assign w_add    = {1'b0, A} + {1'b0, B}  + {{WIDTH{1'b0}}, Cin};
    assign w_sub    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_ov = (A[WIDTH-1] == B[WIDTH-1]) & (w_add[WIDTH-1] != A[WIDTH-1]);
    assign w_sub_ov = (A[WIDTH-1] != B[WIDTH-1]) & (w_sub[WIDTH-1] != A[WIDTH-1]);

    assign w_is_shift = (mode == M_SLL) | (mode == M_SRL) | (mode == M_SRA);
`ifdef ITER_ALU_MUL_EN
    assign w_mul_start = (mode == M_MUL);
`else
    assign w_mul_start = 1'b0;
`endif
    // The first shift/multiply step happens on the accept edge, so only
    // shifts by 2 or more need the BUSY state.
    assign w_long = (w_is_shift & (w_shamt > SHW'(1))) | w_mul_start;

    always_comb begin
        w_res  = '0;
        w_ov   = 1'b0;
        w_cout = 1'b0;
        case (mode)
            M_ADD: begin
                w_res  = w_add[WIDTH-1:0];
                w_ov   = w_add_ov;
                w_cout = w_add[WIDTH];
            end
            M_SUB: begin
                w_res  = w_sub[WIDTH-1:0];
                w_ov   = w_sub_ov;
                w_cout = w_sub[WIDTH];
            end
            M_NOT:  w_res = ~A;
            M_AND:  w_res = A & B;
            M_OR:   w_res = A | B;
            M_XOR:  w_res = A ^ B;
            M_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sub_ov ^ w_sub[WIDTH-1]};
            M_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_sub[WIDTH]};
            M_EQ:   w_res = {{(WIDTH-1){1'b0}}, A == B};
            M_SLL, M_SRL, M_SRA:
                w_res = (w_shamt == '0) ? A : shift1(A, mode);
`ifdef ITER_ALU_MUL_EN
            M_MUL:  w_res = B[0] ? A : '0;
`endif
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_step = shift1(r_res, r_mode);
`ifdef ITER_ALU_MUL_EN
        if (r_mode == M_MUL) begin
            w_step = r_res + (r_opb[0] ? r_opa : '0);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_long ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == SHW'(1)) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= '0;
            r_res  <= '0;
            r_zero <= 1'b0;
            r_ov   <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
`ifdef ITER_ALU_MUL_EN
            r_opa  <= '0;
            r_opb  <= '0;
`endif
        end else if (w_accept) begin
            r_mode <= mode;
            r_res  <= w_res;
            r_zero <= ~|w_res;
            r_ov   <= w_ov;
            r_cout <= w_cout;
            r_cnt  <= (w_shamt == '0) ? '0 : w_shamt - SHW'(1);
`ifdef ITER_ALU_MUL_EN
            if (w_mul_start) begin
                r_cnt <= SHW'(WIDTH - 1);
            end
            r_opa <= A << 1;
            r_opb <= B >> 1;
`endif
        end else if (r_state == S_BUSY) begin
            r_res  <= w_step;
            r_zero <= ~|w_step;
            r_cnt  <= r_cnt - SHW'(1);
`ifdef ITER_ALU_MUL_EN
            r_opa  <= r_opa << 1;
            r_opb  <= r_opb >> 1;
`endif
        end
    end

    assign result   = r_res;
    assign zero     = r_zero;
    assign overflow = r_ov;
    assign Cout     = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// Directed table-driven bench for iter_alu (WIDTH=32), plus backpressure and
// mid-operation reset sequences.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mode;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        Cout;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .Cout      (Cout)
    );

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        co;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   busy_bad;

    function automatic vec_t mk(input logic [3:0] m, input logic [31:0] a,
                                input logic [31:0] b, input logic cin,
                                input logic [31:0] res, input logic z,
                                input logic ov, input logic co, input int lat);
        vec_t v;
        v.mode = m; v.a = a; v.b = b; v.cin = cin;
        v.res = res; v.z = z; v.ov = ov; v.co = co; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issues one op from IDLE, keeps in_valid high with garbage while busy,
    // and returns the presented result plus its latency in cycles.
    task automatic run_op(input vec_t v, output logic [31:0] r, output logic z,
                          output logic ov, output logic co, output int lat);
        mode = v.mode; A = v.a; B = v.b; Cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        A = $urandom; B = $urandom; Cin = ~v.cin; mode = 4'($urandom_range(0, 15));
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        r = result; z = zero; ov = overflow; co = Cout;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, r0;
        logic        z, ov, co;
        int          lat, stale;

        vecs.push_back(mk(4'd0,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
        vecs.push_back(mk(4'd1,  32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1));
        vecs.push_back(mk(4'd1,  32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd1,  32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(4'd2,  32'h0F0F0F0F, 32'h00000000, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd4,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'hFF0FFF0F, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd5,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'hF00FF00F, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd6,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd7,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd8,  32'h00001234, 32'h00001234, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd8,  32'h00001234, 32'h00001235, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd9,  32'h00000003, 32'h00000000, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd9,  32'h00000001, 32'h00000104, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0, 4));
        vecs.push_back(mk(4'd10, 32'h80000000, 32'h00000001, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd11, 32'h80000000, 32'h0000001F, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 31));
        vecs.push_back(mk(4'd10, 32'h80000000, 32'h0000001F, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 31));
`ifdef ITER_ALU_MUL_EN
        vecs.push_back(mk(4'd12, 32'h00010003, 32'h00020005, 1'b0, 32'h000B000F, 1'b0, 1'b0, 1'b0, 32));
`else
        vecs.push_back(mk(4'd12, 32'h00010003, 32'h00020005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
`endif
        vecs.push_back(mk(4'd13, 32'h00000005, 32'h00000007, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = 4'd0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result",    result,          32'd0);
        check("reset.zero",      32'(zero),       32'd0);
        check("reset.overflow",  32'(overflow),   32'd0);
        check("reset.cout",      32'(Cout),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset.in_ready",  32'(in_ready),   32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], r, z, ov, co, lat);
            check($sformatf("v%0d.result", i),   r,              vecs[i].res);
            check($sformatf("v%0d.zero", i),     32'(z),         32'(vecs[i].z));
            check($sformatf("v%0d.overflow", i), 32'(ov),        32'(vecs[i].ov));
            check($sformatf("v%0d.cout", i),     32'(co),        32'(vecs[i].co));
            check($sformatf("v%0d.latency", i),  32'(lat),       32'(vecs[i].lat));
            check($sformatf("v%0d.busy_ready", i), 32'(busy_bad), 32'd0);
        end

        // Backpressure: result and flags must hold while the consumer stalls.
        out_ready = 1'b0;
        run_op(vecs[0], r0, z, ov, co, lat);
        check("bp.first_result", r0, 32'h80000000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d.result", k),    result,          32'h80000000);
            check($sformatf("bp%0d.overflow", k),  32'(overflow),   32'd1);
            check($sformatf("bp%0d.out_valid", k), 32'(out_valid),  32'd1);
            check($sformatf("bp%0d.in_ready", k),  32'(in_ready),   32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release_out_valid", 32'(out_valid), 32'd0);
        check("bp.release_in_ready",  32'(in_ready),  32'd1);
        run_op(mk(4'd0, 32'd1, 32'd2, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1), r, z, ov, co, lat);
        check("bp.next_result",  r,        32'd4);
        check("bp.next_latency", 32'(lat), 32'd1);

        // Reset in cycle 10 of an SRL by 20 discards the op entirely.
        mode = 4'd10; A = 32'hFFFFFFFF; B = 32'd20; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        check("mid.pre_result_nonzero", 32'(result != 32'd0), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.result",    result,         32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid.in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check("mid.no_stale", 32'(stale), 32'd0);
        check("mid.result_after", result, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
